// File: rtl/axis_data_unpack.sv
// axis_data_unpack: reassembles H2C AXI-Stream frames into one wide word plus
// sequence number, checking frame length and sequence continuity.
module axis_data_unpack #(
    parameter int DATA_WIDTH      = 4064,
    parameter int AXIS_DATA_WIDTH = 512
) (
    input  logic                         s_axis_h2c_aclk,
    input  logic                         s_axis_h2c_areset,
    input  logic [AXIS_DATA_WIDTH-1:0]   s_axis_h2c_tdata,
    input  logic [AXIS_DATA_WIDTH/8-1:0] s_axis_h2c_tkeep,
    input  logic                         s_axis_h2c_tlast,
    input  logic                         s_axis_h2c_tvalid,
    output logic                         s_axis_h2c_tready,
    output logic [DATA_WIDTH-1:0]        data_out,
    output logic                         data_valid,
    input  logic                         data_ready,
    output logic [7:0]                   seq_num,
    output logic                         seq_err,
    output logic                         len_err,
    output logic [15:0]                  frame_cnt,
    output logic [1:0]                   sstate
);
    localparam int AW    = AXIS_DATA_WIDTH;
    localparam int BEATS = (DATA_WIDTH + 8 + AW - 1) / AW;
    localparam int BUF_W = BEATS * AW - 8;
    localparam int IW    = BEATS > 1 ? $clog2(BEATS) : 1;
    localparam logic [IW-1:0] LAST = IW'(BEATS - 1);

    typedef enum logic [1:0] {IDLE, COLLECT, DRAIN, HOLD} state_t;

    state_t           state, next_state;
    logic [IW-1:0]    idx;
    logic [BUF_W-1:0] payload;
    logic [7:0]       exp_seq, rx_seq;
    logic             acc, done, len_err_d;
    logic             unused_tkeep;

    assign unused_tkeep      = ^s_axis_h2c_tkeep;
    assign s_axis_h2c_tready = !s_axis_h2c_areset && state != HOLD;
    assign acc               = s_axis_h2c_tvalid && s_axis_h2c_tready;
    assign data_valid        = state == HOLD;
    assign sstate            = state;
    assign data_out          = payload[DATA_WIDTH-1:0];
    // a one-beat frame completes in the same cycle its sequence number arrives
    assign rx_seq            = idx == '0 ? s_axis_h2c_tdata[7:0] : seq_num;

    always_ff @(posedge s_axis_h2c_aclk) begin
        if (s_axis_h2c_areset)
            state <= IDLE;
        else
            state <= next_state;
    end

    // IDLE behaves as COLLECT with the beat index parked at zero
    always_comb begin
        next_state = state;
        len_err_d  = 1'b0;
        done       = 1'b0;
        case (state)
            IDLE, COLLECT: begin
                if (acc && idx == LAST) begin
                    done       = s_axis_h2c_tlast;
                    len_err_d  = !s_axis_h2c_tlast;
                    next_state = s_axis_h2c_tlast ? HOLD : DRAIN;
                end else if (acc) begin
                    len_err_d  = s_axis_h2c_tlast;
                    next_state = s_axis_h2c_tlast ? IDLE : COLLECT;
                end
            end
            DRAIN:   next_state = acc && s_axis_h2c_tlast ? IDLE : DRAIN;
            HOLD:    next_state = data_ready ? IDLE : HOLD;
            default: next_state = IDLE;
        endcase
    end

    always_ff @(posedge s_axis_h2c_aclk) begin
        if (s_axis_h2c_areset) begin
            idx       <= '0;
            payload   <= '0;
            seq_num   <= 8'd0;
            exp_seq   <= 8'd0;
            seq_err   <= 1'b0;
            len_err   <= 1'b0;
            frame_cnt <= 16'd0;
        end else begin
            idx     <= next_state != COLLECT ? '0 : acc ? idx + 1'b1 : idx;
            seq_err <= done && rx_seq != exp_seq;
            len_err <= len_err_d;
            if (done)
                exp_seq <= rx_seq + 8'd1;
            if (state == HOLD && data_ready)
                frame_cnt <= frame_cnt + 16'd1;
            if (acc && (state == IDLE || state == COLLECT)) begin
                if (idx == '0) begin
                    payload[AW-9:0] <= s_axis_h2c_tdata[AW-1:8];
                    seq_num         <= s_axis_h2c_tdata[7:0];
                end
                for (int k = 1; k < BEATS; k++)
                    if (idx == IW'(k))
                        payload[AW-8+AW*(k-1) +: AW] <= s_axis_h2c_tdata;
            end
        end
    end
endmodule
